vadd_stream_kernel: RTL and testbench



---
 rtl/vadd_pkg.sv | 42 ++++
 rtl/vadd_pipe_slice.sv | 39 +++
 rtl/vadd_stream_kernel.sv | 156 +++++++++++++++
 tb/tb_vadd_stream_kernel.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vadd_pkg.sv
// Shared types and the lane adder used by the vector-add streaming kernel.
// lane_add works on a zero-extended lane of up to MAX_LANE_W bits.
package vadd_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_PAIR  = 2'd1,
    MODE_ACCUM = 2'd2
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } fsm_e;

  localparam int MAX_LANE_W = 64;

  // Returns {carry, sum}; operands must already fit in 'width' bits.
  function automatic logic [MAX_LANE_W:0] lane_add(
    input logic [MAX_LANE_W-1:0] a,
    input logic [MAX_LANE_W-1:0] b,
    input int                    width,
    input logic                  sat
  );
    logic [MAX_LANE_W:0] one_s;
    logic [MAX_LANE_W:0] full_s;
    logic [MAX_LANE_W:0] mask_s;
    logic [MAX_LANE_W:0] sum_s;
    logic                carry_s;
    one_s   = {{MAX_LANE_W{1'b0}}, 1'b1};
    full_s  = {1'b0, a} + {1'b0, b};
    mask_s  = (one_s << width) - one_s;
    carry_s = |(full_s & ~mask_s);
    if (sat && carry_s) begin
      sum_s = mask_s;
    end else begin
      sum_s = full_s & mask_s;
    end
    return {carry_s, sum_s[MAX_LANE_W-1:0]};
  endfunction

endpackage

// File: rtl/vadd_pipe_slice.sv
// One elastic register slice: accepts when empty or when the next stage drains it.
module vadd_pipe_slice
  import vadd_pkg::*;
#(
  parameter int C_DATA_WIDTH = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [C_DATA_WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [C_DATA_WIDTH-1:0] out_data
);

  logic                    valid_r;
  logic [C_DATA_WIDTH-1:0] data_r;

  assign in_ready  = !valid_r || out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Data only moves on accept, so it stays stable while the slice is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= 1'b0;
      data_r  <= {C_DATA_WIDTH{1'b0}};
    end else if (in_valid && in_ready) begin
      valid_r <= 1'b1;
      data_r  <= in_data;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/vadd_stream_kernel.sv
// Lane-wise vector add streaming kernel: pass, pair-add and group-accumulate
// front end feeding a chain of elastic output slices.
module vadd_stream_kernel
  import vadd_pkg::*;
#(
  parameter int C_DATA_WIDTH = 512,
  parameter int C_LANE_WIDTH = 32,
  parameter int C_STAGES     = 2,
  parameter int C_SATURATE   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    in_ready,
  input  logic                    in_avail,
  input  logic [C_DATA_WIDTH-1:0] in_data,
  input  logic                    in_last,
  input  logic [1:0]              cfg_mode,
  input  logic                    cfg_clear_ovf,
  input  logic                    out_ready,
  output logic                    out_avail,
  output logic [C_DATA_WIDTH-1:0] out_data,
  output logic                    out_ovf
);

  localparam int C_LANES = C_DATA_WIDTH / C_LANE_WIDTH;

  logic                    released_r;
  fsm_e                    state_r, state_s;
  mode_e                   grp_mode_r, grp_mode_s, req_mode_s;
  logic [C_DATA_WIDTH-1:0] hold_r, hold_s, sum_s, emit_data_s;
  logic [C_LANES-1:0]      carry_vec_s;
  logic                    xfer_s, emit_s, add_used_s, ovf_r;
  logic [C_STAGES-1:0]     slice_valid_s, slice_rdy_s, down_rdy_s;
  logic [C_DATA_WIDTH-1:0] slice_data_s [C_STAGES];
  logic                    rdy_unused_s;

  assign xfer_s       = in_ready && in_avail;
  assign in_ready     = released_r && slice_rdy_s[0];
  assign rdy_unused_s = ^slice_rdy_s;
  assign out_avail    = slice_valid_s[C_STAGES-1];
  assign out_data     = slice_data_s[C_STAGES-1];
  assign out_ovf      = ovf_r;

  for (genvar i = 0; i < C_LANES; i++) begin : g_lane
    logic [MAX_LANE_W-1:0] a_s, b_s;
    logic [MAX_LANE_W:0]   r_s;
    logic                  lane_unused_s;
    // Zero-extend both operands into the shared adder width.
    always_comb begin
      a_s = {MAX_LANE_W{1'b0}};
      b_s = {MAX_LANE_W{1'b0}};
      a_s[C_LANE_WIDTH-1:0] = hold_r[i*C_LANE_WIDTH +: C_LANE_WIDTH];
      b_s[C_LANE_WIDTH-1:0] = in_data[i*C_LANE_WIDTH +: C_LANE_WIDTH];
      r_s = lane_add(a_s, b_s, C_LANE_WIDTH, C_SATURATE != 0);
    end
    assign sum_s[i*C_LANE_WIDTH +: C_LANE_WIDTH] = r_s[C_LANE_WIDTH-1:0];
    assign carry_vec_s[i] = r_s[MAX_LANE_W];
    assign lane_unused_s  = ^r_s;
  end

  // Reserved mode encoding behaves as pass-through.
  always_comb begin
    case (cfg_mode)
      2'd1:    req_mode_s = MODE_PAIR;
      2'd2:    req_mode_s = MODE_ACCUM;
      default: req_mode_s = MODE_PASS;
    endcase
  end

  // Front-end group FSM: decides whether a beat is emitted or absorbed into hold_r.
  always_comb begin
    state_s     = state_r;
    grp_mode_s  = grp_mode_r;
    hold_s      = hold_r;
    emit_s      = 1'b0;
    emit_data_s = in_data;
    add_used_s  = 1'b0;
    if (xfer_s) begin
      case (state_r)
        IDLE: begin
          grp_mode_s = req_mode_s;
          if (req_mode_s == MODE_PASS || in_last) begin
            emit_s = 1'b1;
          end else begin
            hold_s  = in_data;
            state_s = HOLD;
          end
        end
        HOLD: begin
          add_used_s  = 1'b1;
          emit_data_s = sum_s;
          if (grp_mode_r == MODE_ACCUM && !in_last) begin
            hold_s = sum_s;
          end else begin
            emit_s  = 1'b1;
            state_s = IDLE;
          end
        end
        default: state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Ready into slice k: some slice at or beyond k+1 is empty, or the sink accepts.
  always_comb begin
    logic acc_s;
    acc_s      = out_ready;
    down_rdy_s = {C_STAGES{1'b0}};
    for (int k = C_STAGES - 1; k >= 0; k--) begin
      down_rdy_s[k] = acc_s;
      acc_s         = acc_s || !slice_valid_s[k];
    end
  end

  // Group state, partial sum, sticky overflow and the post-reset release flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      released_r <= 1'b0;
      state_r    <= IDLE;
      grp_mode_r <= MODE_PASS;
      hold_r     <= {C_DATA_WIDTH{1'b0}};
      ovf_r      <= 1'b0;
    end else begin
      released_r <= 1'b1;
      state_r    <= state_s;
      grp_mode_r <= grp_mode_s;
      hold_r     <= hold_s;
      ovf_r      <= cfg_clear_ovf ? 1'b0 : (ovf_r || (add_used_s && |carry_vec_s));
    end
  end

  for (genvar k = 0; k < C_STAGES; k++) begin : g_stage
    logic                    in_valid_s;
    logic [C_DATA_WIDTH-1:0] in_data_s;
    if (k == 0) begin : g_head
      assign in_valid_s = xfer_s && emit_s;
      assign in_data_s  = emit_data_s;
    end else begin : g_body
      assign in_valid_s = slice_valid_s[k-1];
      assign in_data_s  = slice_data_s[k-1];
    end
    vadd_pipe_slice #(.C_DATA_WIDTH(C_DATA_WIDTH)) u_slice (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid_s),
      .in_ready  (slice_rdy_s[k]),
      .in_data   (in_data_s),
      .out_valid (slice_valid_s[k]),
      .out_ready (down_rdy_s[k]),
      .out_data  (slice_data_s[k])
    );
  end

endmodule

// File: tb/tb_vadd_stream_kernel.sv
// Self-checking bench: a wrap and a saturating kernel share stimulus and are
// compared every cycle against a group-level behavioural model.
module tb_vadd_stream_kernel;

  localparam int DW = 512;
  localparam int LW = 32;
  localparam int LANES = DW / LW;
  localparam int STAGES = 2;
  localparam longint unsigned LMAX = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_avail = 1'b0;
  logic in_last = 1'b0;
  logic cfg_clear_ovf = 1'b0;
  logic out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic [1:0] cfg_mode = 2'd0;
  logic in_ready_w, out_avail_w, out_ovf_w, in_ready_s, out_avail_s, out_ovf_s;
  logic [DW-1:0] out_data_w, out_data_s;

  typedef struct {
    logic [DW-1:0] w;
    logic [DW-1:0] s;
    int c;
  } exp_t;

  exp_t exp_q[$];
  logic [DW-1:0] got_w[$];
  logic [DW-1:0] got_s[$];
  int got_cyc[$];
  int cyc = 0;
  int n_total = 0;
  int n_pass = 0;
  bit bp_en = 1'b0;
  logic or_val = 1'b1;

  // model state
  bit grp_active = 1'b0;
  logic [1:0] grp_mode = 2'd0;
  logic [DW-1:0] hold_w = '0;
  logic [DW-1:0] hold_s = '0;
  bit exp_ovf_w = 1'b0;
  bit exp_ovf_s = 1'b0;
  bit exp_rel = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vadd_stream_kernel #(.C_DATA_WIDTH(DW), .C_LANE_WIDTH(LW), .C_STAGES(STAGES), .C_SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .in_ready(in_ready_w), .in_avail(in_avail), .in_data(in_data),
    .in_last(in_last), .cfg_mode(cfg_mode), .cfg_clear_ovf(cfg_clear_ovf), .out_ready(out_ready),
    .out_avail(out_avail_w), .out_data(out_data_w), .out_ovf(out_ovf_w));

  vadd_stream_kernel #(.C_DATA_WIDTH(DW), .C_LANE_WIDTH(LW), .C_STAGES(STAGES), .C_SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .in_ready(in_ready_s), .in_avail(in_avail), .in_data(in_data),
    .in_last(in_last), .cfg_mode(cfg_mode), .cfg_clear_ovf(cfg_clear_ovf), .out_ready(out_ready),
    .out_avail(out_avail_s), .out_data(out_data_s), .out_ovf(out_ovf_s));

  function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endfunction

  function automatic logic [DW-1:0] fill(input logic [LW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*LW +: LW] = v;
    return r;
  endfunction

  // Unsigned lane-wise add from first principles on 64-bit integers.
  function automatic logic [DW-1:0] vadd(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input bit sat, output bit carry);
    logic [DW-1:0] r;
    longint unsigned t;
    carry = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      t = longint'(a[i*LW +: LW]) + longint'(b[i*LW +: LW]);
      if (t > LMAX) begin
        carry = 1'b1;
        if (sat) t = LMAX;
      end
      r[i*LW +: LW] = t[LW-1:0];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_vec();
    logic [DW-1:0] r;
    int sel;
    for (int i = 0; i < LANES; i++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0) r[i*LW +: LW] = LW'($urandom_range(0, 255));
      else if (sel == 1) r[i*LW +: LW] = 32'hFFFF_FF00 + LW'($urandom_range(0, 255));
      else r[i*LW +: LW] = $urandom;
    end
    return r;
  endfunction

  // Compare process: sampled on the falling edge, reflects what the next rising edge does.
  initial begin
    bit exp_av, exp_ir, emit, cw, cs;
    logic [1:0] m;
    logic [DW-1:0] ew, es, sw, ss;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_avail_w", DW'(out_avail_w), DW'(0));
        chk("rst_avail_s", DW'(out_avail_s), DW'(0));
        chk("rst_in_ready", DW'(in_ready_w), DW'(0));
        chk("rst_data_w", out_data_w, '0);
        exp_q.delete();
        grp_active = 1'b0; grp_mode = 2'd0; hold_w = '0; hold_s = '0;
        exp_ovf_w = 1'b0; exp_ovf_s = 1'b0; exp_rel = 1'b0;
      end else begin
        exp_ir = exp_rel && (exp_q.size() < STAGES || out_ready);
        chk("in_ready_w", DW'(in_ready_w), DW'(exp_ir));
        chk("in_ready_s", DW'(in_ready_s), DW'(exp_ir));
        exp_av = (exp_q.size() > 0) && (cyc >= exp_q[0].c + STAGES);
        chk("out_avail_w", DW'(out_avail_w), DW'(exp_av));
        chk("out_avail_s", DW'(out_avail_s), DW'(exp_av));
        chk("out_ovf_w", DW'(out_ovf_w), DW'(exp_ovf_w));
        chk("out_ovf_s", DW'(out_ovf_s), DW'(exp_ovf_s));
        if (exp_av) begin
          chk("out_data_w", out_data_w, exp_q[0].w);
          chk("out_data_s", out_data_s, exp_q[0].s);
          if (out_ready) begin
            void'(exp_q.pop_front());
            got_w.push_back(out_data_w);
            got_s.push_back(out_data_s);
            got_cyc.push_back(cyc);
          end
        end
        cw = 1'b0; cs = 1'b0;
        if (in_avail && exp_ir) begin
          m = grp_active ? grp_mode : ((cfg_mode == 2'd3) ? 2'd0 : cfg_mode);
          emit = 1'b0; ew = in_data; es = in_data;
          if (!grp_active) begin
            if (m == 2'd0 || in_last) emit = 1'b1;
            else begin grp_active = 1'b1; grp_mode = m; hold_w = in_data; hold_s = in_data; end
          end else begin
            sw = vadd(hold_w, in_data, 1'b0, cw);
            ss = vadd(hold_s, in_data, 1'b1, cs);
            if (grp_mode == 2'd1 || in_last) begin emit = 1'b1; ew = sw; es = ss; grp_active = 1'b0; end
            else begin hold_w = sw; hold_s = ss; end
          end
          if (emit) exp_q.push_back('{w: ew, s: es, c: cyc});
        end
        exp_ovf_w = cfg_clear_ovf ? 1'b0 : (exp_ovf_w | cw);
        exp_ovf_s = cfg_clear_ovf ? 1'b0 : (exp_ovf_s | cs);
        exp_rel = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    out_ready = bp_en ? 1'($urandom_range(0, 1)) : or_val;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last, input logic [1:0] mode, output int acc);
    bit done;
    done = 1'b0; acc = -1;
    in_avail = 1'b1; in_data = d; in_last = last; cfg_mode = mode;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (in_ready_w) begin acc = cyc; done = 1'b1; end
      step();
    end
    if (!done) chk("send_timeout", DW'(0), DW'(1));
    in_avail = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    in_avail = 1'b0;
    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) step();
    chk("drain_empty", DW'(exp_q.size()), DW'(0));
  endtask

  task automatic clear_got();
    got_w.delete(); got_s.delete(); got_cyc.delete();
  endtask

  initial begin
    int a0, a;
    logic [DW-1:0] v;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_avail", DW'(out_avail_w), DW'(0));
    chk("reset_data", out_data_w, '0);
    chk("reset_ovf", DW'(out_ovf_w), DW'(0));
    chk("reset_in_ready", DW'(in_ready_w), DW'(0));
    reset = 1'b1;
    step();

    // PASS: 8 back-to-back beats, lane i = i
    for (int i = 0; i < LANES; i++) v[i*LW +: LW] = LW'(i);
    clear_got();
    send(v, 1'b0, 2'd0, a0);
    for (int n = 1; n < 8; n++) send(v, 1'b0, 2'd0, a);
    drain();
    chk("t1_count", DW'(got_w.size()), DW'(8));
    for (int j = 0; j < got_w.size(); j++) chk("t1_data", got_w[j], v);
    if (got_cyc.size() == 8) begin
      chk("t1_latency", DW'(got_cyc[0]), DW'(a0 + 2));
      chk("t1_continuous", DW'(got_cyc[7] - got_cyc[0]), DW'(7));
    end

    // PAIR: 5+7, then 1,2,3(last)
    clear_got();
    send(fill(32'd5), 1'b0, 2'd1, a);
    send(fill(32'd7), 1'b0, 2'd1, a);
    send(fill(32'd1), 1'b0, 2'd1, a);
    send(fill(32'd2), 1'b0, 2'd1, a);
    send(fill(32'd3), 1'b1, 2'd1, a);
    drain();
    chk("t2_count", DW'(got_w.size()), DW'(3));
    if (got_w.size() == 3) begin
      chk("t2_pair", got_w[0], fill(32'd12));
      chk("t2_pair2", got_w[1], fill(32'd3));
      chk("t2_tail", got_w[2], fill(32'd3));
    end

    // ACCUM 10,20,30(last) with cfg_mode moved to PASS mid-group
    clear_got();
    send(fill(32'd10), 1'b0, 2'd2, a);
    send(fill(32'd20), 1'b0, 2'd0, a);
    send(fill(32'd30), 1'b1, 2'd0, a);
    send(fill(32'd9), 1'b0, 2'd0, a);
    drain();
    chk("t3_count", DW'(got_w.size()), DW'(2));
    if (got_w.size() == 2) begin
      chk("t3_accum", got_w[0], fill(32'd60));
      chk("t3_next_pass", got_w[1], fill(32'd9));
    end

    // Overflow: wrap vs saturate, then clear
    chk("t4_ovf_before", DW'(out_ovf_w), DW'(0));
    clear_got();
    send(fill(32'hFFFF_FFF0), 1'b0, 2'd2, a);
    send(fill(32'h0000_0020), 1'b1, 2'd2, a);
    drain();
    chk("t4_count", DW'(got_w.size()), DW'(1));
    if (got_w.size() == 1) begin
      chk("t4_wrap", got_w[0], fill(32'h0000_0010));
      chk("t4_sat", got_s[0], fill(32'hFFFF_FFFF));
    end
    chk("t4_ovf_w", DW'(out_ovf_w), DW'(1));
    chk("t4_ovf_s", DW'(out_ovf_s), DW'(1));
    cfg_clear_ovf = 1'b1;
    step();
    cfg_clear_ovf = 1'b0;
    chk("t4_clear_w", DW'(out_ovf_w), DW'(0));
    chk("t4_clear_s", DW'(out_ovf_s), DW'(0));

    // Back-pressure: 200 PASS beats, then 200 mixed-mode beats
    bp_en = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin in_avail = 1'b0; step(); end
      send(rnd_vec(), 1'($urandom_range(0, 1)), 2'd0, a);
    end
    for (int n = 0; n < 200; n++) begin
      cfg_clear_ovf = ($urandom_range(0, 7) == 0);
      send(rnd_vec(), ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), a);
    end
    cfg_clear_ovf = 1'b0;
    send(rnd_vec(), 1'b1, 2'd0, a);
    drain();
    bp_en = 1'b0;
    step();

    // Reset while ACCUM holds a partial sum and one result is stalled at the output
    or_val = 1'b0;
    step();
    send(fill(32'd3), 1'b1, 2'd0, a);
    send(fill(32'hFFFF_FFF0), 1'b0, 2'd2, a);
    send(fill(32'h0000_0020), 1'b0, 2'd2, a);
    chk("t6_pre_avail", DW'(out_avail_w), DW'(1));
    chk("t6_pre_ovf", DW'(out_ovf_w), DW'(1));
    reset = 1'b0;
    #1;
    chk("t6_rst_avail", DW'(out_avail_w), DW'(0));
    chk("t6_rst_data", out_data_w, '0);
    chk("t6_rst_ovf", DW'(out_ovf_w), DW'(0));
    chk("t6_rst_ovf_s", DW'(out_ovf_s), DW'(0));
    chk("t6_rst_in_ready", DW'(in_ready_w), DW'(0));
    or_val = 1'b1;
    step();
    reset = 1'b1;
    #1;
    chk("t6_rel_before_edge", DW'(in_ready_w), DW'(0));
    step();
    chk("t6_rel_after_edge", DW'(in_ready_w), DW'(1));
    clear_got();
    send(fill(32'd4), 1'b1, 2'd2, a);
    drain();
    chk("t6_count", DW'(got_w.size()), DW'(1));
    if (got_w.size() == 1) begin
      chk("t6_fresh_w", got_w[0], fill(32'd4));
      chk("t6_fresh_s", got_s[0], fill(32'd4));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
